mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execution-stage multiply/divide unit holding the HI/LO registers.
- Consumes the MD-class control decoded upstream: mult, multu, div, divu, madd, mthi, mtlo, mfhi, mflo.
- Models multi-cycle latency with a busy counter and generates the D-stage stall request for any MD-class instruction that would collide with a running operation.

Parameters:
MULT_LAT, 5, busy cycles for mult/multu/madd (must be >= 1)
DIV_LAT, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
md_valid  input  1  E-stage instruction is a valid (not flushed) MD-class op
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 mthi, 7 mtlo
A  input  32  rs operand (forwarded)
B  input  32  rt operand (forwarded)
rd_sel  input  1  0 selects HI, 1 selects LO (mfhi/mflo)
md_type_d  input  1  D-stage instruction is MD-class (MDtype decode)
md_out  output  32  rd_sel ? LO : HI, combinational from the registers
busy  output  1  operation in progress
stall  output  1  D-stage stall request
hi_q  output  32  HI register
lo_q  output  32  LO register

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - HI = LO = 0, counter = 0, busy = 0, pending result discarded.
  - stall then follows the equation below with busy = 0.
- start = md_valid & md_op in {1..5} & ~busy.
  - An op 1..5 presented while busy is ignored; the pipeline guarantees this cannot happen.
- On a start edge:
  - Latch the pending result {p_hi, p_lo}.
  - Load counter = MULT_LAT (ops 1, 2, 5) or DIV_LAT (ops 3, 4).
  - Latch a div-by-zero flag.
  - busy = (counter != 0). It rises the cycle after start and stays high exactly LAT cycles.
- Each busy cycle the counter decrements.
  - On the edge where it goes 1 -> 0, commit HI = p_hi, LO = p_lo, unless the div-by-zero flag is set.
  - busy falls the same edge. The new HI/LO are visible on md_out the cycle busy is low.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; {HI, LO} = product.
  - multu: unsigned 64-bit product.
  - madd: {HI, LO} = {HI, LO} + signed(A)*signed(B), mod 2^64. The HI/LO snapshot is taken at start; HI/LO cannot change while busy.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - Divisor 0 (div/divu): HI and LO are left unchanged. Full DIV_LAT busy still applies.
- mthi / mtlo:
  - When md_valid & ~busy, write A into HI or LO on the next edge. No busy.
  - Ignored when busy.
- mfhi / mflo: purely combinational read via md_out. Returns the current register value, never the pending result.
- stall = md_type_d & (busy | start).
  - A D-stage MD instruction stalls while an op runs and on the start cycle itself.
  - stall deasserts the cycle busy falls.
- Back-to-back:
  - A new start is accepted in the first cycle busy is low.
  - mthi/mtlo in the commit-visible cycle overwrites the committed value normally.

Test Plan:
- mult A=0xFFFFFFFD (-3), B=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_out with rd_sel=1 gives 0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. Then madd A=B=0xFFFFFFFF (-1*-1) -> HI=0x00000001, LO=0xFFFFFFFF.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy 10 cycles, HI/LO stay 0x11/0x22.
- md_type_d=1 held from the start cycle -> stall high on the start cycle plus all MULT_LAT busy cycles, low the first cycle busy=0. A second mult presented while busy is ignored: result still from the first op.
- Assert reset 3 cycles into a div -> busy=0, HI=LO=0 immediately (asynchronous). No commit occurs after reset release.
- mtlo A=0x12345678 while idle -> LO=0x12345678 next cycle, busy stays 0. The same mtlo while busy -> LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// Execution-stage multiply/divide unit: owns HI/LO, models multi-cycle
// latency with a down-counter and raises the D-stage stall request.
module mult_div_unit #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    input  logic        md_type_d,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MADD  = 3'd5,
        OP_MTHI  = 3'd6,
        OP_MTLO  = 3'd7
    } md_op_e;

    localparam int unsigned MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CW     = $clog2(MAXLAT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          dbz_q, dbz_d;
    logic [31:0]   hi_d, lo_d;

    logic          start, is_div, is_arith;
    logic [63:0]   prod_s, prod_u, res;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, b_mag_safe, b_safe;
    logic [31:0]   uq, ur, sq, sr, dq, dr;

    assign busy     = (cnt_q != '0);
    assign is_arith = (md_op == OP_MULT) || (md_op == OP_MULTU) || (md_op == OP_DIV) ||
                      (md_op == OP_DIVU) || (md_op == OP_MADD);
    assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign start    = md_valid && is_arith && !busy;
    assign stall    = md_type_d && (busy || start);
    assign md_out   = rd_sel ? lo_q : hi_q;

    // Pending-result arithmetic; signed division goes through magnitudes so
    // 0x80000000 / -1 is well defined and remainder takes the dividend sign.
    always_comb begin
        prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u     = {32'd0, A} * {32'd0, B};
        a_neg      = A[31];
        b_neg      = B[31];
        a_mag      = a_neg ? (~A + 32'd1) : A;
        b_mag      = b_neg ? (~B + 32'd1) : B;
        b_mag_safe = (B == '0) ? 32'd1 : b_mag;
        b_safe     = (B == '0) ? 32'd1 : B;
        uq         = a_mag / b_mag_safe;
        ur         = a_mag % b_mag_safe;
        sq         = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        sr         = a_neg ? (~ur + 32'd1) : ur;
        dq         = A / b_safe;
        dr         = A % b_safe;
        res        = '0;
        case (md_op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {sr, sq};
            OP_DIVU:  res = {dr, dq};
            OP_MADD:  res = {hi_q, lo_q} + prod_s;
            default:  res = '0;
        endcase
    end

    // Next-state: start loads counter/pending result, commit on 1 -> 0,
    // mthi/mtlo write only while idle.
    always_comb begin
        cnt_d = cnt_q;
        phi_d = phi_q;
        plo_d = plo_q;
        dbz_d = dbz_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start) begin
            phi_d = res[63:32];
            plo_d = res[31:0];
            cnt_d = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            dbz_d = is_div && (B == '0);
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
            if ((cnt_q == CW'(1)) && !dbz_q) begin
                hi_d = phi_q;
                lo_d = plo_q;
            end
        end
        if (md_valid && !busy && (md_op == OP_MTHI)) hi_d = A;
        if (md_valid && !busy && (md_op == OP_MTLO)) lo_d = A;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            phi_q <= '0;
            plo_q <= '0;
            dbz_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            dbz_q <= dbz_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {HI,LO} pushed when an op
// starts, popped and compared when busy falls.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        rd_sel;
    logic        md_type_d;
    logic [31:0] md_out;
    logic        busy;
    logic        stall;
    logic [31:0] hi_q, lo_q;

    int checks;
    int failures;
    logic [63:0] exp_q[$];

    mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
        .A(A), .B(B), .rd_sel(rd_sel), .md_type_d(md_type_d),
        .md_out(md_out), .busy(busy), .stall(stall), .hi_q(hi_q), .lo_q(lo_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an op at the falling edge so it is seen at the next rising edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_valid = 1'b1; md_op = op; A = a; B = b;
    endtask

    task automatic release_op;
        @(posedge clk); #1;
        md_valid = 1'b0; md_op = 3'd0;
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [31:0] val);
        start_op(op, val, 32'd0);
        release_op();
    endtask

    // Count busy cycles after a start edge; bounded so it cannot hang.
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        md_type_d = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (hi_q !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_q); end
        checks++; if (lo_q !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_q); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        md_type_d = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_mult;
        int n; logic [63:0] e;
        start_op(3'd1, 32'hFFFFFFFD, 32'd5);
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
        release_op();
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL mult_lat got=%0d exp=5", n); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL mult_res got=%h exp=%h", {hi_q, lo_q}, e); end
        rd_sel = 1'b1; #1;
        checks++; if (md_out !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_mdout_lo got=%h exp=fffffff1", md_out); end
        rd_sel = 1'b0; #1;
        checks++; if (md_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_mdout_hi got=%h exp=ffffffff", md_out); end
    endtask

    task automatic test_multu_madd;
        int n; logic [63:0] e;
        start_op(3'd2, 32'hFFFFFFFF, 32'd2);
        exp_q.push_back(64'h00000001_FFFFFFFE);
        release_op();
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL multu_lat got=%0d exp=5", n); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL multu_res got=%h exp=%h", {hi_q, lo_q}, e); end
        start_op(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        exp_q.push_back(64'h00000001_FFFFFFFF);
        release_op();
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL madd_lat got=%0d exp=5", n); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL madd_res got=%h exp=%h", {hi_q, lo_q}, e); end
    endtask

    task automatic test_div;
        int n; logic [63:0] e;
        logic [31:0] da[3] = '{32'hFFFFFFF9, 32'h80000000, 32'd7};
        logic [31:0] db[3] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [63:0] de[3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000000_80000000, 64'h00000001_FFFFFFFD};
        for (int i = 0; i < 3; i++) begin
            start_op(3'd3, da[i], db[i]);
            exp_q.push_back(de[i]);
            release_op();
            wait_done(n);
            checks++; if (n != 10) begin failures++; $display("FAIL div_lat[%0d] got=%0d exp=10", i, n); end
            e = exp_q.pop_front();
            checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL div_res[%0d] got=%h exp=%h", i, {hi_q, lo_q}, e); end
        end
    endtask

    task automatic test_divu_zero;
        int n; logic [63:0] e;
        write_reg(3'd6, 32'h11);
        write_reg(3'd7, 32'h22);
        start_op(3'd4, 32'd7, 32'd0);
        exp_q.push_back(64'h00000011_00000022);
        release_op();
        wait_done(n);
        checks++; if (n != 10) begin failures++; $display("FAIL divu0_lat got=%0d exp=10", n); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL divu0_res got=%h exp=%h", {hi_q, lo_q}, e); end
        start_op(3'd4, 32'd100, 32'd7);
        exp_q.push_back(64'h00000002_0000000E);
        release_op();
        wait_done(n);
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL divu_res got=%h exp=%h", {hi_q, lo_q}, e); end
    endtask

    task automatic test_stall;
        int n; logic [63:0] e;
        md_type_d = 1'b1;
        start_op(3'd1, 32'd6, 32'd7);
        exp_q.push_back(64'h00000000_0000002A);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_start got=%0b exp=1", stall); end
        release_op();
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_busy[%0d] got=%0b exp=1", n, stall); end
            if (n == 2) begin md_valid = 1'b1; md_op = 3'd1; A = 32'd9; B = 32'd9; end
            if (n == 3) begin md_valid = 1'b0; md_op = 3'd0; end
            n++;
            @(negedge clk);
        end
        checks++; if (n != 5) begin failures++; $display("FAIL stall_lat got=%0d exp=5", n); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", stall); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL ignore_second got=%h exp=%h", {hi_q, lo_q}, e); end
        md_type_d = 1'b0;
    endtask

    task automatic test_mtlo;
        int n; logic [63:0] e;
        write_reg(3'd7, 32'h12345678);
        @(negedge clk);
        checks++; if (lo_q !== 32'h12345678) begin failures++; $display("FAIL mtlo_idle got=%h exp=12345678", lo_q); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mtlo_busy got=%0b exp=0", busy); end
        start_op(3'd1, 32'd2, 32'd3);
        exp_q.push_back(64'h00000000_00000006);
        release_op();
        @(negedge clk);
        md_valid = 1'b1; md_op = 3'd7; A = 32'hDEADBEEF;
        release_op();
        @(negedge clk);
        checks++; if (lo_q !== 32'h12345678) begin failures++; $display("FAIL mtlo_while_busy got=%h exp=12345678", lo_q); end
        wait_done(n);
        checks++; if (n != 3) begin failures++; $display("FAIL mtlo_remaining got=%0d exp=3", n); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL mtlo_mult_res got=%h exp=%h", {hi_q, lo_q}, e); end
    endtask

    task automatic test_reset_mid;
        write_reg(3'd6, 32'h55);
        write_reg(3'd7, 32'h66);
        start_op(3'd3, 32'd100, 32'd7);
        release_op();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++; if (hi_q !== 32'd0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", hi_q); end
        checks++; if (lo_q !== 32'd0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", lo_q); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if ({busy, hi_q, lo_q} !== 65'd0) begin failures++; $display("FAIL rstmid_nocommit got=%0b/%h/%h exp=0/0/0", busy, hi_q, lo_q); end
    endtask

    task automatic test_back_to_back;
        int n; logic [63:0] e;
        start_op(3'd1, 32'd3, 32'd4);
        exp_q.push_back(64'h00000000_0000000C);
        release_op();
        wait_done(n);
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {hi_q, lo_q}, e); end
        md_valid = 1'b1; md_op = 3'd2; A = 32'h00010000; B = 32'h00010000;
        exp_q.push_back(64'h00000001_00000000);
        release_op();
        wait_done(n);
        checks++; if (n != 5) begin failures++; $display("FAIL b2b_accept got=%0d exp=5", n); end
        e = exp_q.pop_front();
        checks++; if ({hi_q, lo_q} !== e) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {hi_q, lo_q}, e); end
        md_valid = 1'b1; md_op = 3'd6; A = 32'h0000AAAA;
        release_op();
        @(negedge clk);
        checks++; if ({hi_q, lo_q} !== 64'h0000AAAA_00000000) begin failures++; $display("FAIL b2b_mthi got=%h exp=0000aaaa00000000", {hi_q, lo_q}); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; md_valid = 1'b0; md_op = 3'd0; A = '0; B = '0;
        rd_sel = 1'b0; md_type_d = 1'b0;
        test_reset();
        test_mult();
        test_multu_madd();
        test_div();
        test_divu_zero();
        test_stall();
        test_mtlo();
        test_reset_mid();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
